// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect/kill handling,
// WFI sleep, and registered fetch exceptions (misaligned target, page fault).
module fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [3:0]  EXC_NONE     = 4'd14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_new_pc_req,
   input  logic [31:0] csr_new_pc,
   input  logic        exe_new_pc_req,
   input  logic [31:0] exe_new_pc,
   input  logic        wfi_req,
   input  logic        irq_wake,
   input  logic        id_ready,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        imem_page_fault_i,
   output logic        if_valid_o,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic        exc_req_o,
   output logic [3:0]  exc_code_o
);

   localparam logic [3:0] ExcMisalign   = 4'd0;
   localparam logic [3:0] ExcPageFault  = 4'd12;

   typedef enum logic [2:0] {
      StFetch,
      StKill,
      StValid,
      StFault,
      StSleep
   } state_e;

   state_e      state_q, state_d;
   state_e      post_q, post_d;
   state_e      redir_post;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic        exc_q, exc_d;
   logic [3:0]  code_q, code_d;

   logic        redirect;
   logic [31:0] target;
   logic        ack;
   logic        pf_hit;

   always_comb begin
      state_d  = state_q;
      post_d   = post_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      if_pc_d  = if_pc_q;
      code_d   = code_q;
      pf_hit   = 1'b0;

      redirect   = csr_new_pc_req | exe_new_pc_req;
      target     = csr_new_pc_req ? csr_new_pc : exe_new_pc;
      // req_q is low in FETCH only on the cycle after reset, so a stray ack there is ignored
      ack        = imem_ack_i & req_q;
      redir_post = (target[1:0] != 2'b00) ? StFault : StFetch;

      unique case (state_q)
         StFetch: begin
            if (redirect) begin
               pc_d    = target;
               post_d  = redir_post;
               state_d = (ack || !req_q) ? redir_post : StKill;
            end else if (wfi_req) begin
               post_d  = StSleep;
               state_d = (ack || !req_q) ? StSleep : StKill;
            end else if (ack) begin
               if (imem_page_fault_i) begin
                  state_d = StFault;
                  pf_hit  = 1'b1;
               end else begin
                  state_d = StValid;
               end
            end
         end
         StKill: begin
            if (redirect) begin
               pc_d   = target;
               post_d = redir_post;
            end else if (wfi_req && post_q == StFetch) begin
               post_d = StSleep;
            end
            if (ack) begin
               state_d = post_d;
            end
         end
         StValid: begin
            if (redirect) begin
               pc_d    = target;
               state_d = redir_post;
            end else if (wfi_req) begin
               state_d = StSleep;
            end else if (id_ready) begin
               pc_d    = pc_q + 32'd4;
               state_d = StFetch;
            end
         end
         StFault: begin
            if (redirect) begin
               pc_d    = target;
               state_d = redir_post;
            end
         end
         StSleep: begin
            if (redirect) begin
               pc_d    = target;
               state_d = redir_post;
            end else if (irq_wake) begin
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StFetch;
         end
      endcase

      // Side effects keyed on the state being entered
      if (state_d == StValid && state_q != StValid) begin
         instr_d = imem_rdata_i;
         if_pc_d = pc_q;
      end

      if (state_d == StFault) begin
         if (state_q != StFault || redirect) begin
            code_d  = pf_hit ? ExcPageFault : ExcMisalign;
            if_pc_d = pc_d;
         end
      end else begin
         code_d = EXC_NONE;
      end

      if (state_d == StFetch) begin
         addr_d = pc_d;
      end

      valid_d = (state_d == StValid);
      exc_d   = (state_d == StFault);
      req_d   = (state_d == StFetch) || (state_d == StKill);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
         post_q  <= StFetch;
         pc_q    <= RESET_VECTOR;
         addr_q  <= RESET_VECTOR;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         instr_q <= 32'h0;
         if_pc_q <= RESET_VECTOR;
         exc_q   <= 1'b0;
         code_q  <= EXC_NONE;
      end else begin
         state_q <= state_d;
         post_q  <= post_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         if_pc_q <= if_pc_d;
         exc_q   <= exc_d;
         code_q  <= code_d;
      end
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = addr_q;
   assign if_valid_o  = valid_q;
   assign if_instr_o  = instr_q;
   assign if_pc_o     = if_pc_q;
   assign exc_req_o   = exc_q;
   assign exc_code_o  = code_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: cycle-by-cycle vector table plus hand sequences.
module tb_fetch_ctrl;

   localparam int CmdNone = 0;
   localparam int CmdRst  = 1;
   localparam int CmdCsr  = 2;
   localparam int CmdExe  = 3;
   localparam int CmdBoth = 4;
   localparam int CmdWfi  = 5;
   localparam int CmdWake = 6;

   typedef struct {
      int          cmd;
      logic [31:0] tgt;
      logic        rdy;
      logic        ack;
      logic        pf;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic        e_exc;
      logic [3:0]  e_code;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        csr_new_pc_req = 1'b0;
   logic [31:0] csr_new_pc = 32'h0;
   logic        exe_new_pc_req = 1'b0;
   logic [31:0] exe_new_pc = 32'h0;
   logic        wfi_req = 1'b0;
   logic        irq_wake = 1'b0;
   logic        id_ready = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        imem_page_fault_i = 1'b0;
   logic        if_valid_o;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic        exc_req_o;
   logic [3:0]  exc_code_o;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   step     = 0;
   vec_t tbl[$];

   fetch_ctrl #(
      .RESET_VECTOR (32'h0000_0000),
      .EXC_NONE     (4'd14)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .csr_new_pc_req    (csr_new_pc_req),
      .csr_new_pc        (csr_new_pc),
      .exe_new_pc_req    (exe_new_pc_req),
      .exe_new_pc        (exe_new_pc),
      .wfi_req           (wfi_req),
      .irq_wake          (irq_wake),
      .id_ready          (id_ready),
      .imem_req_o        (imem_req_o),
      .imem_addr_o       (imem_addr_o),
      .imem_ack_i        (imem_ack_i),
      .imem_rdata_i      (imem_rdata_i),
      .imem_page_fault_i (imem_page_fault_i),
      .if_valid_o        (if_valid_o),
      .if_instr_o        (if_instr_o),
      .if_pc_o           (if_pc_o),
      .exc_req_o         (exc_req_o),
      .exc_code_o        (exc_code_o)
   );

   always #5 clk = ~clk;

   task automatic add(input int cmd, input logic [31:0] tgt, input int rdy, input int ack,
                      input int pf, input int req, input logic [31:0] addr, input int valid,
                      input logic [31:0] pc, input int exc, input int code);
      vec_t v;
      v.cmd     = cmd;
      v.tgt     = tgt;
      v.rdy     = (rdy != 0);
      v.ack     = (ack != 0);
      v.pf      = (pf != 0);
      v.e_req   = (req != 0);
      v.e_addr  = addr;
      v.e_valid = (valid != 0);
      v.e_pc    = pc;
      v.e_exc   = (exc != 0);
      v.e_code  = 4'(code);
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got %h, expected %h", step, name, got, exp);
      end
   endtask

   // Memory returns a word derived from the address so the latched instruction is traceable
   task automatic apply(input vec_t v);
      step++;
      rst            = (v.cmd == CmdRst);
      csr_new_pc_req = (v.cmd == CmdCsr) || (v.cmd == CmdBoth);
      csr_new_pc     = v.tgt;
      exe_new_pc_req = (v.cmd == CmdExe) || (v.cmd == CmdBoth);
      exe_new_pc     = (v.cmd == CmdBoth) ? v.tgt + 32'h100 : v.tgt;
      wfi_req        = (v.cmd == CmdWfi);
      irq_wake       = (v.cmd == CmdWake);
      id_ready       = v.rdy;
      imem_ack_i     = v.ack;
      imem_page_fault_i = v.pf;
      imem_rdata_i   = imem_addr_o + 32'h13;
      @(posedge clk);
      #1;
      chk("imem_req",  32'(imem_req_o), 32'(v.e_req));
      chk("imem_addr", imem_addr_o, v.e_addr);
      chk("if_valid",  32'(if_valid_o), 32'(v.e_valid));
      chk("if_pc",     if_pc_o, v.e_pc);
      chk("exc_req",   32'(exc_req_o), 32'(v.e_exc));
      chk("exc_code",  32'(exc_code_o), 32'(v.e_code));
      if (v.e_valid) chk("if_instr", if_instr_o, v.e_pc + 32'h13);
   endtask

   task automatic run1(input int cmd, input logic [31:0] tgt, input int rdy, input int ack,
                       input int pf, input int req, input logic [31:0] addr, input int valid,
                       input logic [31:0] pc, input int exc, input int code);
      tbl.delete();
      add(cmd, tgt, rdy, ack, pf, req, addr, valid, pc, exc, code);
      apply(tbl[0]);
   endtask

   initial begin
      // cmd      tgt           rdy ack pf  req addr          vld pc            exc code
      add(CmdRst,  32'h0,        0,  1,  0,  0, 32'h0,         0, 32'h0,         0, 14);
      add(CmdNone, 32'h0,        0,  1,  0,  1, 32'h0,         0, 32'h0,         0, 14);
      add(CmdNone, 32'h0,        0,  0,  0,  1, 32'h0,         0, 32'h0,         0, 14);
      add(CmdNone, 32'h0,        0,  1,  0,  0, 32'h0,         1, 32'h0,         0, 14);
      add(CmdNone, 32'h0,        1,  0,  0,  1, 32'h4,         0, 32'h0,         0, 14);
      add(CmdNone, 32'h0,        0,  1,  0,  0, 32'h4,         1, 32'h4,         0, 14);
      add(CmdNone, 32'h0,        0,  0,  0,  0, 32'h4,         1, 32'h4,         0, 14);
      add(CmdNone, 32'h0,        1,  0,  0,  1, 32'h8,         0, 32'h4,         0, 14);
      add(CmdExe,  32'h100,      0,  0,  0,  1, 32'h8,         0, 32'h4,         0, 14);
      add(CmdNone, 32'h0,        0,  0,  0,  1, 32'h8,         0, 32'h4,         0, 14);
      add(CmdNone, 32'h0,        0,  0,  0,  1, 32'h8,         0, 32'h4,         0, 14);
      add(CmdNone, 32'h0,        0,  1,  1,  1, 32'h100,       0, 32'h4,         0, 14);
      add(CmdNone, 32'h0,        0,  1,  0,  0, 32'h100,       1, 32'h100,       0, 14);
      add(CmdNone, 32'h0,        1,  0,  0,  1, 32'h104,       0, 32'h100,       0, 14);
      add(CmdBoth, 32'h200,      0,  1,  0,  1, 32'h200,       0, 32'h100,       0, 14);
      add(CmdNone, 32'h0,        0,  1,  0,  0, 32'h200,       1, 32'h200,       0, 14);
      add(CmdExe,  32'h102,      0,  0,  0,  0, 32'h200,       0, 32'h102,       1, 0);
      add(CmdNone, 32'h0,        0,  0,  0,  0, 32'h200,       0, 32'h102,       1, 0);
      add(CmdWfi,  32'h0,        0,  0,  0,  0, 32'h200,       0, 32'h102,       1, 0);
      add(CmdCsr,  32'h400,      0,  0,  0,  1, 32'h400,       0, 32'h102,       0, 14);
      add(CmdExe,  32'h1000,     0,  0,  0,  1, 32'h400,       0, 32'h102,       0, 14);
      add(CmdNone, 32'h0,        0,  1,  0,  1, 32'h1000,      0, 32'h102,       0, 14);
      add(CmdNone, 32'h0,        0,  1,  1,  0, 32'h1000,      0, 32'h1000,      1, 12);
      add(CmdCsr,  32'hFFFFFFFC, 0,  0,  0,  1, 32'hFFFFFFFC,  0, 32'h1000,      0, 14);
      add(CmdNone, 32'h0,        0,  1,  0,  0, 32'hFFFFFFFC,  1, 32'hFFFFFFFC,  0, 14);
      add(CmdWfi,  32'h0,        0,  0,  0,  0, 32'hFFFFFFFC,  0, 32'hFFFFFFFC,  0, 14);
      for (int i = 0; i < 9; i++) begin
         add(CmdNone, 32'h0,     0,  0,  0,  0, 32'hFFFFFFFC,  0, 32'hFFFFFFFC,  0, 14);
      end
      add(CmdWake, 32'h0,        0,  0,  0,  1, 32'hFFFFFFFC,  0, 32'hFFFFFFFC,  0, 14);
      add(CmdNone, 32'h0,        0,  1,  0,  0, 32'hFFFFFFFC,  1, 32'hFFFFFFFC,  0, 14);
      add(CmdNone, 32'h0,        1,  0,  0,  1, 32'h0,         0, 32'hFFFFFFFC,  0, 14);
      add(CmdNone, 32'h0,        0,  1,  0,  0, 32'h0,         1, 32'h0,         0, 14);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
      end

      // WFI with a request outstanding goes through KILL; a redirect wakes from SLEEP
      run1(CmdNone, 32'h0,       1,  0,  0,  1, 32'h4,         0, 32'h0,         0, 14);
      run1(CmdWfi,  32'h0,       0,  0,  0,  1, 32'h4,         0, 32'h0,         0, 14);
      run1(CmdNone, 32'h0,       0,  1,  0,  0, 32'h4,         0, 32'h0,         0, 14);
      for (int i = 0; i < 3; i++) begin
         run1(CmdNone, 32'h0,    0,  0,  0,  0, 32'h4,         0, 32'h0,         0, 14);
      end
      run1(CmdExe,  32'h20,      0,  0,  0,  1, 32'h20,        0, 32'h0,         0, 14);
      run1(CmdNone, 32'h0,       0,  1,  0,  0, 32'h20,        1, 32'h20,        0, 14);

      // Misaligned redirect while killing a faulting response, then reset mid-request
      run1(CmdNone, 32'h0,       1,  0,  0,  1, 32'h24,        0, 32'h20,        0, 14);
      run1(CmdExe,  32'h31,      0,  0,  0,  1, 32'h24,        0, 32'h20,        0, 14);
      run1(CmdNone, 32'h0,       0,  1,  1,  0, 32'h24,        0, 32'h31,        1, 0);
      run1(CmdExe,  32'h40,      0,  0,  0,  1, 32'h40,        0, 32'h31,        0, 14);
      run1(CmdRst,  32'h0,       0,  1,  0,  0, 32'h0,         0, 32'h0,         0, 14);
      run1(CmdNone, 32'h0,       0,  1,  0,  1, 32'h0,         0, 32'h0,         0, 14);
      run1(CmdNone, 32'h0,       0,  1,  0,  0, 32'h0,         1, 32'h0,         0, 14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
